// File: rtl/cricket_scorer.sv
// Cricket scoring engine: samples the LFSR on each deliver rising edge and updates the scoreboard two cycles after the edge.
// No backpressure: edges during scoring or after the innings ends are dropped. FREE_HIT_EN enables the no-ball free-hit rule.
module cricket_scorer #(
  parameter int MAX_OVERS   = 2,
  parameter int MAX_WICKETS = 10,
  parameter int RUN_W       = 9,
  parameter int OVER_W      = 5
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic              deliver,
  input  logic              new_innings,
  input  logic [3:0]        rnd,
  output logic [RUN_W-1:0]  runs,
  output logic [RUN_W-1:0]  extras,
  output logic [3:0]        wickets,
  output logic [2:0]        balls,
  output logic [OVER_W-1:0] overs,
  output logic [3:0]        outcome,
  output logic              outcome_valid,
  output logic              free_hit,
  output logic              innings_over
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_SCORE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state, w_state_nx;

  logic              r_deliver_q;
  logic [3:0]        r_rnd_q;
  logic [RUN_W-1:0]  r_runs, r_extras, w_runs_nx, w_extras_nx;
  logic [3:0]        r_wickets, w_wickets_nx;
  logic [2:0]        r_balls, w_balls_nx;
  logic [OVER_W-1:0] r_overs, w_overs_nx;
  logic [3:0]        r_outcome, w_outcome_nx;
  logic              r_valid, w_valid_nx;
  logic              r_free_hit, w_free_hit_nx;

  logic              w_edge;
  logic [2:0]        w_add;
  logic              w_legal, w_extra, w_wkt;
  logic [RUN_W:0]    w_runs_sum, w_extras_sum;
  logic [RUN_W-1:0]  w_runs_sat, w_extras_sat;

  assign w_edge = deliver & ~r_deliver_q;

  always_comb begin
    w_add   = 3'd0;
    w_legal = 1'b1;
    w_extra = 1'b0;
    w_wkt   = 1'b0;
    case (r_rnd_q)
      4'd3, 4'd4, 4'd5, 4'd6: w_add = 3'd1;
      4'd7, 4'd8, 4'd9:       w_add = 3'd2;
      4'd10:                  w_add = 3'd3;
      4'd11:                  w_add = 3'd4;
      4'd12:                  w_add = 3'd6;
      4'd13, 4'd14: begin
        w_add   = 3'd1;
        w_legal = 1'b0;
        w_extra = 1'b1;
      end
      4'd15: begin
`ifdef FREE_HIT_EN
        w_wkt = ~r_free_hit;
`else
        w_wkt = 1'b1;
`endif
      end
      default: w_add = 3'd0;
    endcase
  end

  // Runs and extras stop at all-ones rather than wrapping.
  assign w_runs_sum   = {1'b0, r_runs} + {{(RUN_W-2){1'b0}}, w_add};
  assign w_extras_sum = {1'b0, r_extras} + {{RUN_W{1'b0}}, w_extra};
  assign w_runs_sat   = w_runs_sum[RUN_W] ? {RUN_W{1'b1}} : w_runs_sum[RUN_W-1:0];
  assign w_extras_sat = w_extras_sum[RUN_W] ? {RUN_W{1'b1}} : w_extras_sum[RUN_W-1:0];

  always_comb begin
    w_state_nx    = r_state;
    w_runs_nx     = r_runs;
    w_extras_nx   = r_extras;
    w_wickets_nx  = r_wickets;
    w_balls_nx    = r_balls;
    w_overs_nx    = r_overs;
    w_outcome_nx  = r_outcome;
    w_valid_nx    = 1'b0;
    w_free_hit_nx = r_free_hit;
    case (r_state)
      ST_PLAY: begin
        if (w_edge) w_state_nx = ST_SCORE;
      end
      ST_SCORE: begin
        w_valid_nx   = 1'b1;
        w_outcome_nx = r_rnd_q;
        w_runs_nx    = w_runs_sat;
        w_extras_nx  = w_extras_sat;
        if (w_wkt) w_wickets_nx = r_wickets + 4'd1;
        if (w_legal) begin
          if (r_balls == 3'd5) begin
            w_balls_nx = 3'd0;
            w_overs_nx = r_overs + {{(OVER_W-1){1'b0}}, 1'b1};
          end else begin
            w_balls_nx = r_balls + 3'd1;
          end
        end
`ifdef FREE_HIT_EN
        if (r_rnd_q == 4'd14) w_free_hit_nx = 1'b1;
        else if (w_legal)     w_free_hit_nx = 1'b0;
`else
        w_free_hit_nx = 1'b0;
`endif
        if (w_wickets_nx == 4'(MAX_WICKETS) || w_overs_nx == OVER_W'(MAX_OVERS))
          w_state_nx = ST_DONE;
        else
          w_state_nx = ST_PLAY;
      end
      ST_DONE: w_state_nx = ST_DONE;
      default: w_state_nx = ST_PLAY;
    endcase
    // A new innings wins over a same-cycle edge or a ball waiting to be scored.
    if (new_innings) begin
      w_state_nx    = ST_PLAY;
      w_runs_nx     = '0;
      w_extras_nx   = '0;
      w_wickets_nx  = '0;
      w_balls_nx    = '0;
      w_overs_nx    = '0;
      w_outcome_nx  = '0;
      w_valid_nx    = 1'b0;
      w_free_hit_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) r_state <= ST_PLAY;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      r_deliver_q <= 1'b0;
      r_rnd_q     <= '0;
      r_runs      <= '0;
      r_extras    <= '0;
      r_wickets   <= '0;
      r_balls     <= '0;
      r_overs     <= '0;
      r_outcome   <= '0;
      r_valid     <= 1'b0;
      r_free_hit  <= 1'b0;
    end else begin
      r_deliver_q <= deliver;
      if (r_state == ST_PLAY && w_edge) r_rnd_q <= rnd;
      r_runs      <= w_runs_nx;
      r_extras    <= w_extras_nx;
      r_wickets   <= w_wickets_nx;
      r_balls     <= w_balls_nx;
      r_overs     <= w_overs_nx;
      r_outcome   <= w_outcome_nx;
      r_valid     <= w_valid_nx;
      r_free_hit  <= w_free_hit_nx;
    end
  end

  assign runs          = r_runs;
  assign extras        = r_extras;
  assign wickets       = r_wickets;
  assign balls         = r_balls;
  assign overs         = r_overs;
  assign outcome       = r_outcome;
  assign outcome_valid = r_valid;
  assign free_hit      = r_free_hit;
  assign innings_over  = (r_state == ST_DONE);

endmodule

// File: doc/cricket_scorer.md
Name: cricket_scorer

Overview:
- Scoring engine for the FPGA cricket game, directly downstream of the 4-bit LFSR random source.
- On each delivery request it samples the LFSR value and decodes it into a ball outcome.
- It updates runs, extras, wickets, balls and overs, and flags end of innings for the display/UI logic.

Parameters:
- MAX_OVERS, 2, overs per innings (1..2^OVER_W-1)
- MAX_WICKETS, 10, wickets ending the innings (1..15)
- RUN_W, 9, width of runs counter
- OVER_W, 5, width of overs counter

Ports:
- clk_fpga  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low reset
- deliver  in  1  delivery request level, already synchronised/debounced; rising edge = one ball
- new_innings  in  1  single-cycle pulse; clears innings
- rnd  in  4  LFSR_RANDOM_NUMBER from the LFSR stage
- runs  out  RUN_W  total runs incl. extras
- extras  out  RUN_W  wide + no-ball runs
- wickets  out  4  wickets fallen
- balls  out  3  legal balls in current over, 0..5
- overs  out  OVER_W  completed overs
- outcome  out  4  last decoded outcome code
- outcome_valid  out  1  one-cycle pulse when counters take a new ball
- free_hit  out  1  next legal ball is a free hit
- innings_over  out  1  high in DONE state

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; deliver_q 0; state PLAY.
- Edge detect: deliver_q <= deliver every cycle, in all states; edge = deliver & ~deliver_q.
- States: PLAY, SCORE, DONE.
- PLAY: on edge, rnd_q <= rnd and go to SCORE. No edge: stay.
- SCORE: apply decode of rnd_q. Counters, outcome and outcome_valid=1 register on this clock. Next state is DONE if the end condition is met, else PLAY.
- Edges arriving while in SCORE are dropped.
- Latency: edge in cycle N; counters and outcome_valid visible in cycle N+2.
- Decode of rnd_q (outcome = rnd_q):
  - 0-2 dot: +0 runs, legal
  - 3-6 single: +1, legal
  - 7-9 double: +2, legal
  - 10 triple: +3, legal
  - 11 four: +4, legal
  - 12 six: +6, legal
  - 13 wide: +1 runs, +1 extras, not legal
  - 14 no-ball: +1 runs, +1 extras, not legal
  - 15 wicket: +0 runs, wickets+1, legal
- Legal ball: balls+1. When balls would reach 6, balls <= 0 and overs+1 in the same update.
- runs and extras saturate at 2^RUN_W-1; no wrap.
- End condition after update: wickets == MAX_WICKETS, or overs == MAX_OVERS. innings_over=1 from the cycle state enters DONE.
- DONE: deliveries ignored; counters frozen; outcome_valid stays 0.
- new_innings, in any state:
  - Next cycle: runs, extras, wickets, balls, overs, outcome, free_hit and innings_over are 0; state is PLAY.
  - Has priority over a simultaneous edge or a pending SCORE; that ball is discarded.
- Asynchronous reset mid-SCORE: ball discarded, full reset values.

Optional Feature:
- Macro FREE_HIT_EN.
- Defined:
  - A no-ball sets free_hit=1.
  - free_hit persists through wides and no-balls.
  - The next legal ball clears it.
  - If that legal ball decodes as 15, it is scored as a dot (outcome still 15, wickets unchanged, ball counted).
- Not defined: free_hit tied to 0; code 15 always takes a wicket.

Test Plan:
- Reset low, then release; hold rnd=12 with no deliver edge for 20 cycles -> all outputs 0, outcome_valid never asserts.
- Deliver edges with rnd=11,12,5,0,9,3 -> runs=4,10,11,11,13,14; balls 1,2,3,4,5 then balls=0, overs=1 on the sixth ball; outcome_valid exactly 2 cycles after each edge.
- rnd=13 then 14 -> runs+2, extras=2, balls unchanged.
  - With FREE_HIT_EN, rnd=14 then 15 -> free_hit 1 then 0, wickets=0, balls+1.
  - Without FREE_HIT_EN, the same sequence -> wickets=1.
- MAX_WICKETS=2, rnd=15 twice -> wickets=2, innings_over=1; a further edge with rnd=12 leaves runs unchanged and outcome_valid stays 0.
- MAX_OVERS=1, six legal balls -> overs=1, innings_over=1; new_innings pulse -> all counters 0, innings_over=0 next cycle.
- deliver held high 10 cycles -> exactly one ball scored; new_innings in the same cycle as an edge -> no ball scored, counters 0.
